// File: rtl/ifetch_unit.sv
// Instruction fetch front end: fetches the word at the PC and queues {pc, instr} pairs for decode.
// Latency: grant in cycle N, response no earlier than N+1, id_valid at N+2 (one instruction per 2 cycles peak).
// Backpressure: a full queue withholds ibus_req and holds the PC; only a registered pop frees a slot.
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    output logic        pc_stall,
    input  logic        flush,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_gnt,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // REQ: free to issue; WAIT_RSP: response owed and wanted; DISCARD: response owed but stale
    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_RSP = 2'd1,
        S_DISCARD  = 2'd2
    } state_t;

    state_t        state_q;
    logic [31:0]   pend_pc_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic empty;
    logic space;
    logic grant;
    logic push;
    logic pop;
    logic unused_pc_lsbs;

    // The bus only sees word addresses; the low PC bits are intentionally dropped.
    assign ibus_addr      = {pc_addr[31:2], 2'b00};
    assign unused_pc_lsbs = ^pc_addr[1:0];

    assign empty = (count_q == '0);
    // Credit comes from the registered count only, so a same-cycle pop never opens a slot.
    assign space = (count_q < DEPTH_C);

    // Flush masks the request so a PC load and a PC advance can never coincide.
    assign ibus_req = rst & (state_q == S_REQ) & space & ~flush;
    assign grant    = ibus_req & ibus_gnt;
    assign pc_stall = ~(rst & (flush | grant));

    assign push     = (state_q == S_WAIT_RSP) & ibus_rvalid & ~flush;
    assign id_valid = rst & ~empty & ~flush;
    assign pop      = id_valid & id_ready;

    assign id_instr = empty ? 32'h0 : ins_mem_q[rd_ptr_q];
    assign id_pc    = empty ? 32'h0 : pc_mem_q[rd_ptr_q];

    // Fetch sequencing: one outstanding request, stale responses are swallowed after a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_REQ;
            pend_pc_q <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (grant) begin
                        pend_pc_q <= ibus_addr;
                        state_q   <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (ibus_rvalid) begin
                        state_q <= S_REQ;
                    end else if (flush) begin
                        state_q <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (ibus_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // Queue bookkeeping: flush empties it outright and overrides any push or pop on that edge.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage; contents are only visible through a valid head, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= pend_pc_q;
            ins_mem_q[wr_ptr_q] <= ibus_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        pc_stall;
    logic        flush;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .pc_stall   (pc_stall),
        .flush      (flush),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_gnt   (ibus_gnt),
        .ibus_rvalid(ibus_rvalid),
        .ibus_rdata (ibus_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    int checks = 0;
    int errors = 0;

    // External PC register and the redirect target presented with flush.
    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic [31:0] flush_tgt;
    assign pc_addr = pc_q;

    // Reference model: queue of delivered {pc, instr}, plus "a response is owed" and "it is stale".
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    bit          m_out;
    bit          m_poison;
    logic [31:0] m_out_pc;

    // Expected outputs for the current cycle.
    bit          e_req, e_stall, e_valid;
    logic [31:0] e_pc, e_ins, e_addr;

    task automatic model_clear();
        mq_pc.delete();
        mq_ins.delete();
        m_out    = 1'b0;
        m_poison = 1'b0;
    endtask

    // Wait to mid-cycle and derive what the outputs must be from the model and current inputs.
    task automatic sample();
        @(negedge clk);
        if (!rst) model_clear();
        e_req   = rst && !m_out && (mq_pc.size() < DEPTH) && !flush;
        e_stall = !(rst && (flush || (e_req && ibus_gnt)));
        e_valid = rst && (mq_pc.size() != 0) && !flush;
        e_pc    = (mq_pc.size() != 0) ? mq_pc[0] : 32'h0;
        e_ins   = (mq_ins.size() != 0) ? mq_ins[0] : 32'h0;
        e_addr  = {pc_q[31:2], 2'b00};
    endtask

    // Apply this cycle's events to the model, cross the clock edge, then move the PC.
    task automatic advance();
        pc_nxt = pc_q;
        if (rst) begin
            if (flush) begin
                mq_pc.delete();
                mq_ins.delete();
                if (m_out) begin
                    if (ibus_rvalid) begin
                        m_out    = 1'b0;
                        m_poison = 1'b0;
                    end else begin
                        m_poison = 1'b1;
                    end
                end
            end else begin
                if (e_valid && id_ready) begin
                    void'(mq_pc.pop_front());
                    void'(mq_ins.pop_front());
                end
                if (m_out && ibus_rvalid) begin
                    if (!m_poison) begin
                        mq_pc.push_back(m_out_pc);
                        mq_ins.push_back(ibus_rdata);
                    end
                    m_out    = 1'b0;
                    m_poison = 1'b0;
                end else if (e_req && ibus_gnt) begin
                    m_out    = 1'b1;
                    m_poison = 1'b0;
                    m_out_pc = e_addr;
                end
            end
            if (!e_stall) pc_nxt = flush ? flush_tgt : pc_q + 32'd4;
        end else begin
            model_clear();
        end
        @(posedge clk);
        #1;
        pc_q = pc_nxt;
    endtask

    task automatic do_reset();
        flush       = 1'b0;
        ibus_gnt    = 1'b0;
        ibus_rvalid = 1'b0;
        ibus_rdata  = 32'h0;
        id_ready    = 1'b0;
        rst         = 1'b0;
        sample();
        advance();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b1; ibus_gnt = 1'b1; ibus_rvalid = 1'b1; id_ready = 1'b1;
        ibus_rdata = 32'hDEAD_BEEF; pc_q = 32'h0000_1236;
        sample();
        checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", ibus_req); end
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b exp=1", pc_stall); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
        checks++; if (ibus_addr !== 32'h0000_1234) begin errors++; $display("FAIL rst_addr got=%h exp=00001234", ibus_addr); end
        advance();
    endtask

    task automatic test_first_fetch();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        pc_q = 32'h0; ibus_gnt = 1'b1; id_ready = 1'b1;
        sample();
        checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL ff_req got=%b exp=1", ibus_req); end
        checks++; if (ibus_addr !== 32'h0) begin errors++; $display("FAIL ff_addr got=%h exp=0", ibus_addr); end
        checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL ff_stall got=%b exp=0", pc_stall); end
        advance();
        ibus_rvalid = 1'b1; ibus_rdata = d;
        sample();
        checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL ff_wait_req got=%b exp=0", ibus_req); end
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL ff_wait_stall got=%b exp=1", pc_stall); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ff_early_valid got=%b exp=0", id_valid); end
        advance();
        ibus_rvalid = 1'b0; ibus_gnt = 1'b0;
        sample();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ff_valid got=%b exp=1", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL ff_pc got=%h exp=0", id_pc); end
        checks++; if (id_instr !== d) begin errors++; $display("FAIL ff_instr got=%h exp=%h", id_instr, d); end
        checks++; if (ibus_addr !== 32'h4) begin errors++; $display("FAIL ff_next_addr got=%h exp=4", ibus_addr); end
        advance();
        sample();
        checks++; if (id_instr !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL ff_empty got=%b/%h exp=0/0", id_valid, id_instr); end
        advance();
    endtask

    task automatic test_fifo_full();
        logic [31:0] d0, d1;
        d0 = $urandom; d1 = $urandom;
        do_reset();
        pc_q = 32'h0; ibus_gnt = 1'b1; id_ready = 1'b0;
        sample(); advance();
        ibus_rvalid = 1'b1; ibus_rdata = d0; sample(); advance();
        ibus_rvalid = 1'b0; sample();
        checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h4) begin errors++; $display("FAIL full_second_req got=%b/%h exp=1/4", ibus_req, ibus_addr); end
        advance();
        ibus_rvalid = 1'b1; ibus_rdata = d1; sample(); advance();
        ibus_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL full_req c%0d got=%b exp=0", k, ibus_req); end
            checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL full_stall c%0d got=%b exp=1", k, pc_stall); end
            checks++; if (ibus_addr !== 32'h8) begin errors++; $display("FAIL full_addr c%0d got=%h exp=8", k, ibus_addr); end
            advance();
        end
        id_ready = 1'b1;
        sample();
        checks++; if (id_pc !== 32'h0 || id_instr !== d0) begin errors++; $display("FAIL full_pop got=%h/%h exp=0/%h", id_pc, id_instr, d0); end
        checks++; if (ibus_req !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL full_pop_credit got=%b/%b exp=0/1", ibus_req, pc_stall); end
        advance();
        id_ready = 1'b0;
        sample();
        checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h8 || pc_stall !== 1'b0) begin errors++; $display("FAIL full_resume got=%b/%h/%b exp=1/8/0", ibus_req, ibus_addr, pc_stall); end
        checks++; if (id_pc !== 32'h4 || id_instr !== d1) begin errors++; $display("FAIL full_head got=%h/%h exp=4/%h", id_pc, id_instr, d1); end
        advance();
    endtask

    task automatic test_flush_wait();
        logic [31:0] g;
        g = $urandom;
        do_reset();
        pc_q = 32'h0; ibus_gnt = 1'b1; id_ready = 1'b0;
        sample(); advance();
        ibus_rvalid = 1'b1; ibus_rdata = $urandom; sample(); advance();
        ibus_rvalid = 1'b0; sample(); advance();
        flush = 1'b1; flush_tgt = 32'h100;
        sample();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fw_valid_in_flush got=%b exp=0", id_valid); end
        checks++; if (ibus_req !== 1'b0 || pc_stall !== 1'b0) begin errors++; $display("FAIL fw_flush_req_stall got=%b/%b exp=0/0", ibus_req, pc_stall); end
        advance();
        flush = 1'b0;
        sample();
        checks++; if (ibus_req !== 1'b0 || pc_stall !== 1'b1 || id_valid !== 1'b0) begin errors++; $display("FAIL fw_discard got=%b/%b/%b exp=0/1/0", ibus_req, pc_stall, id_valid); end
        advance();
        ibus_rvalid = 1'b1; ibus_rdata = 32'hBAD0_BAD0;
        sample();
        checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL fw_stale_req got=%b exp=0", ibus_req); end
        advance();
        ibus_rvalid = 1'b0;
        sample();
        checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h100 || pc_stall !== 1'b0) begin errors++; $display("FAIL fw_redirect got=%b/%h/%b exp=1/100/0", ibus_req, ibus_addr, pc_stall); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fw_stale_pushed got=%b exp=0", id_valid); end
        advance();
        ibus_rvalid = 1'b1; ibus_rdata = g; ibus_gnt = 1'b0; sample(); advance();
        ibus_rvalid = 1'b0;
        sample();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== g) begin errors++; $display("FAIL fw_first got=%b/%h/%h exp=1/100/%h", id_valid, id_pc, id_instr, g); end
        advance();
    endtask

    task automatic test_flush_rvalid();
        logic [31:0] g;
        g = $urandom;
        do_reset();
        pc_q = 32'h0; ibus_gnt = 1'b1; id_ready = 1'b0;
        sample(); advance();
        ibus_rvalid = 1'b1; ibus_rdata = $urandom; sample(); advance();
        ibus_rvalid = 1'b0;
        sample();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL fr_one_entry got=%b exp=1", id_valid); end
        advance();
        flush = 1'b1; flush_tgt = 32'h200; ibus_rvalid = 1'b1; ibus_rdata = 32'hBAD1_BAD1;
        sample(); advance();
        flush = 1'b0; ibus_rvalid = 1'b0;
        sample();
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL fr_emptied got=%b/%h exp=0/0", id_valid, id_pc); end
        checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin errors++; $display("FAIL fr_redirect got=%b/%h exp=1/200", ibus_req, ibus_addr); end
        advance();
        ibus_rvalid = 1'b1; ibus_rdata = g; ibus_gnt = 1'b0; sample(); advance();
        ibus_rvalid = 1'b0;
        sample();
        checks++; if (id_pc !== 32'h200 || id_instr !== g) begin errors++; $display("FAIL fr_first got=%h/%h exp=200/%h", id_pc, id_instr, g); end
        advance();
    endtask

    task automatic test_grant_delay();
        do_reset();
        pc_q = 32'h40; ibus_gnt = 1'b0; id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h40 || pc_stall !== 1'b1) begin errors++; $display("FAIL gd_hold c%0d got=%b/%h/%b exp=1/40/1", k, ibus_req, ibus_addr, pc_stall); end
            advance();
        end
        ibus_gnt = 1'b1;
        sample();
        checks++; if (ibus_req !== 1'b1 || pc_stall !== 1'b0) begin errors++; $display("FAIL gd_grant got=%b/%b exp=1/0", ibus_req, pc_stall); end
        advance();
        ibus_gnt = 1'b0;
        sample();
        checks++; if (ibus_req !== 1'b0 || ibus_addr !== 32'h44) begin errors++; $display("FAIL gd_after got=%b/%h exp=0/44", ibus_req, ibus_addr); end
        advance();
    endtask

    task automatic test_reset_wait();
        logic [31:0] g;
        g = $urandom;
        do_reset();
        pc_q = 32'h0; ibus_gnt = 1'b1; id_ready = 1'b0;
        sample(); advance();
        ibus_rvalid = 1'b1; ibus_rdata = $urandom; sample(); advance();
        ibus_rvalid = 1'b0; sample(); advance();
        rst = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || ibus_req !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL rw_async got=%b/%b/%b exp=0/0/1", id_valid, ibus_req, pc_stall); end
        sample(); advance();
        rst = 1'b1;
        sample();
        checks++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h8 || id_valid !== 1'b0) begin errors++; $display("FAIL rw_restart got=%b/%h/%b exp=1/8/0", ibus_req, ibus_addr, id_valid); end
        advance();
        ibus_rvalid = 1'b1; ibus_rdata = g; ibus_gnt = 1'b0; sample(); advance();
        ibus_rvalid = 1'b0;
        sample();
        checks++; if (id_pc !== 32'h8 || id_instr !== g) begin errors++; $display("FAIL rw_first got=%h/%h exp=8/%h", id_pc, id_instr, g); end
        advance();
    endtask

    task automatic test_back_to_back();
        int grants, pops;
        grants = 0; pops = 0;
        do_reset();
        pc_q = 32'h0; ibus_gnt = 1'b1; id_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ibus_rvalid = m_out;
            ibus_rdata  = $urandom;
            sample();
            if (ibus_req && ibus_gnt) grants++;
            if (id_valid && id_ready) pops++;
            checks++; if (id_valid !== e_valid || id_pc !== e_pc) begin errors++; $display("FAIL b2b_head c%0d got=%b/%h exp=%b/%h", c, id_valid, id_pc, e_valid, e_pc); end
            advance();
        end
        checks++; if (grants != 10) begin errors++; $display("FAIL b2b_grants got=%0d exp=10", grants); end
        checks++; if (pops != 9) begin errors++; $display("FAIL b2b_pops got=%0d exp=9", pops); end
    endtask

    task automatic test_random(input int n);
        do_reset();
        pc_q = $urandom;
        for (int c = 0; c < n; c++) begin
            flush       = ($urandom_range(0, 99) < 8);
            flush_tgt   = $urandom;
            ibus_gnt    = ($urandom_range(0, 99) < 60);
            ibus_rvalid = m_out ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
            ibus_rdata  = $urandom;
            id_ready    = ($urandom_range(0, 99) < 50);
            sample();
            checks++; if (ibus_req !== e_req) begin errors++; $display("FAIL rnd_req c%0d got=%b exp=%b", c, ibus_req, e_req); end
            checks++; if (pc_stall !== e_stall) begin errors++; $display("FAIL rnd_stall c%0d got=%b exp=%b", c, pc_stall, e_stall); end
            checks++; if (ibus_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c%0d got=%h exp=%h", c, ibus_addr, e_addr); end
            checks++; if (id_valid !== e_valid) begin errors++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, id_valid, e_valid); end
            checks++; if (id_pc !== e_pc) begin errors++; $display("FAIL rnd_pc c%0d got=%h exp=%h", c, id_pc, e_pc); end
            checks++; if (id_instr !== e_ins) begin errors++; $display("FAIL rnd_instr c%0d got=%h exp=%h", c, id_instr, e_ins); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; flush_tgt = 32'h0; ibus_gnt = 1'b0; ibus_rvalid = 1'b0;
        ibus_rdata = 32'h0; id_ready = 1'b0; pc_q = 32'h0;
        model_clear();
        test_reset();
        test_first_fetch();
        test_fifo_full();
        test_flush_wait();
        test_flush_rvalid();
        test_grant_delay();
        test_reset_wait();
        test_back_to_back();
        test_random(3000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
